// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port RAM access controller for the CPU Valid/RW/Ready handshake
module mem_access_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Valid,
    input  logic              RW,
    input  logic [AWIDTH-1:0] Addr_in,
    input  logic [DWIDTH-1:0] Data_in,
    output logic [DWIDTH-1:0] Data_out,
    output logic              Ready,
    output logic              busy,
    output logic              ovr,
    output logic              rdEn,
    output logic              wrEn,
    output logic [AWIDTH-1:0] Addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rw_q;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Valid) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addr and ram_wdata are the request latches themselves, so they stay put through the access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q      <= 1'b0;
            cnt       <= 4'd0;
            Addr      <= '0;
            ram_wdata <= '0;
            Data_out  <= '0;
            ovr       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Valid) begin
                        rw_q      <= RW;
                        Addr      <= Addr_in;
                        ram_wdata <= Data_in;
                        cnt       <= RW ? RD_CNT : WR_CNT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (rw_q) begin
                        Data_out <= ram_rdata;
                    end
                end
                default: ;
            endcase
            if (Valid && (state != IDLE)) begin
                ovr <= 1'b1;
            end
        end
    end

    assign Ready = (state == DONE);
    assign busy  = (state != IDLE);
    assign rdEn  = (state == REQ) &&  rw_q;
    assign wrEn  = (state == REQ) && !rw_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  valid;
    logic        rw;
    logic [7:0]  addr_in;
    logic [31:0] data_in;
    logic [31:0] dout [3];
    logic [2:0]  ready, busy, ovr, rden, wren;
    logic [7:0]  addr_o [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic [31:0] mem [256];
    int          rd_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DWIDTH(32), .AWIDTH(8), .RD_LAT(2), .WR_LAT(1)) u0 (
        .clk(clk), .reset(reset), .Valid(valid[0]), .RW(rw), .Addr_in(addr_in), .Data_in(data_in),
        .Data_out(dout[0]), .Ready(ready[0]), .busy(busy[0]), .ovr(ovr[0]), .rdEn(rden[0]),
        .wrEn(wren[0]), .Addr(addr_o[0]), .ram_wdata(wdat[0]), .ram_rdata(rdat[0]));

    mem_access_ctrl #(.DWIDTH(32), .AWIDTH(8), .RD_LAT(1), .WR_LAT(15)) u1 (
        .clk(clk), .reset(reset), .Valid(valid[1]), .RW(rw), .Addr_in(addr_in), .Data_in(data_in),
        .Data_out(dout[1]), .Ready(ready[1]), .busy(busy[1]), .ovr(ovr[1]), .rdEn(rden[1]),
        .wrEn(wren[1]), .Addr(addr_o[1]), .ram_wdata(wdat[1]), .ram_rdata(rdat[1]));

    mem_access_ctrl #(.DWIDTH(32), .AWIDTH(8), .RD_LAT(15), .WR_LAT(15)) u2 (
        .clk(clk), .reset(reset), .Valid(valid[2]), .RW(rw), .Addr_in(addr_in), .Data_in(data_in),
        .Data_out(dout[2]), .Ready(ready[2]), .busy(busy[2]), .ovr(ovr[2]), .rdEn(rden[2]),
        .wrEn(wren[2]), .Addr(addr_o[2]), .ram_wdata(wdat[2]), .ram_rdata(rdat[2]));

    // RAM behind u0: data is presented only in the cycle RD_LAT=2 cycles after rdEn
    always @(posedge clk) begin
        if (wren[0]) mem[addr_o[0]] <= wdat[0];
        if (rden[0]) rd_cnt <= 2;
        else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    end
    assign rdat[0] = (rd_cnt == 1) ? mem[addr_o[0]] : 32'hBAD0_BAD0;
    assign rdat[1] = {24'h0, addr_o[1]} ^ 32'hA5A5_0000;
    assign rdat[2] = {24'h0, addr_o[2]} ^ 32'h5A5A_0000;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int inst, input logic r, input logic [7:0] a, input logic [31:0] d,
                          output int rdy, output int nrd, output int nwr, output int nbusy);
        rdy = -1; nrd = 0; nwr = 0; nbusy = 0;
        valid[inst] = 1'b1; rw = r; addr_in = a; data_in = d;
        step;
        valid[inst] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            nrd   += int'(rden[inst]);
            nwr   += int'(wren[inst]);
            nbusy += int'(busy[inst]);
            if (ready[inst]) begin
                rdy = c;
                break;
            end
            step;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = '0; rw = 1'b0; addr_in = '0; data_in = '0;
        step; step;
        checks++; if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", ready); end
        checks++; if (rden !== 3'b000 || wren !== 3'b000) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 000", rden, wren); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", busy); end
        checks++; if (ovr !== 3'b000) begin errors++; $display("FAIL reset_ovr: got %b expected 000", ovr); end
        checks++; if (dout[0] !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout[0]); end
        checks++; if (addr_o[0] !== 8'h0 || wdat[0] !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", addr_o[0], wdat[0]); end
        reset = 1'b0;
        step;
    endtask

    task automatic test_read;
        mem[8'h15] = 32'hDEADBEEF;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL read_busy_c0: got %b expected 0", busy[0]); end
        valid[0] = 1'b1; rw = 1'b1; addr_in = 8'h15;
        step;
        valid[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++; if (busy[0] !== (c <= 4)) begin errors++; $display("FAIL read_busy c%0d: got %b expected %b", c, busy[0], (c <= 4)); end
            checks++; if (rden[0] !== (c == 1)) begin errors++; $display("FAIL read_rden c%0d: got %b expected %b", c, rden[0], (c == 1)); end
            checks++; if (ready[0] !== (c == 4)) begin errors++; $display("FAIL read_ready c%0d: got %b expected %b", c, ready[0], (c == 4)); end
            checks++; if (wren[0] !== 1'b0) begin errors++; $display("FAIL read_wren c%0d: got %b expected 0", c, wren[0]); end
            if (c == 1) begin
                checks++; if (addr_o[0] !== 8'h15) begin errors++; $display("FAIL read_addr: got %h expected 15", addr_o[0]); end
            end
            if (c == 4) begin
                checks++; if (dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", dout[0]); end
            end
            step;
        end
    endtask

    task automatic test_write_read;
        int rdy, nrd, nwr, nb;
        do_req(0, 1'b0, 8'h3A, 32'h12345678, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 3) begin errors++; $display("FAIL write_ready_cycle: got %0d expected 3", rdy); end
        checks++; if (nwr !== 1 || nrd !== 0) begin errors++; $display("FAIL write_strobes: got wr=%0d rd=%0d expected 1/0", nwr, nrd); end
        checks++; if (wdat[0] !== 32'h12345678) begin errors++; $display("FAIL write_wdata: got %h expected 12345678", wdat[0]); end
        checks++; if (dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dout_kept: got %h expected deadbeef", dout[0]); end
        checks++; if (mem[8'h3A] !== 32'h12345678) begin errors++; $display("FAIL write_mem: got %h expected 12345678", mem[8'h3A]); end
        step;
        do_req(0, 1'b1, 8'h3A, 32'h0, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 4) begin errors++; $display("FAIL wr_rd_ready_cycle: got %0d expected 4", rdy); end
        checks++; if (dout[0] !== 32'h12345678) begin errors++; $display("FAIL wr_rd_data: got %h expected 12345678", dout[0]); end
        step;
    endtask

    task automatic test_overrun;
        int nrd = 0, nwr = 0;
        valid[0] = 1'b1; rw = 1'b1; addr_in = 8'h15;
        step;
        rw = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) valid[0] = 1'b0;
            nrd += int'(rden[0]);
            nwr += int'(wren[0]);
            if (c == 1) begin
                checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL ovr_c1: got %b expected 0", ovr[0]); end
            end
            if (c == 2) begin
                checks++; if (ovr[0] !== 1'b1) begin errors++; $display("FAIL ovr_c2: got %b expected 1", ovr[0]); end
            end
            step;
        end
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL ovr_strobes: got rd=%0d wr=%0d expected 1/0", nrd, nwr); end
        checks++; if (dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL ovr_data: got %h expected deadbeef", dout[0]); end
        repeat (20) step;
        checks++; if (ovr[0] !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", ovr[0]); end
    endtask

    task automatic test_reset_mid_read;
        int rdy, nrd, nwr, nb;
        mem[8'h01] = 32'h0C0F_FEE1;
        valid[0] = 1'b1; rw = 1'b1; addr_in = 8'h15;
        step;
        valid[0] = 1'b0;
        step;
        reset = 1'b1;
        #1;
        checks++; if (rden[0] !== 1'b0 || ready[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_ready: got %b/%b expected 0/0", rden[0], ready[0]); end
        checks++; if (busy[0] !== 1'b0 || ovr[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_ovr: got %b/%b expected 0/0", busy[0], ovr[0]); end
        checks++; if (dout[0] !== 32'h0) begin errors++; $display("FAIL rst_mid_dout: got %h expected 0", dout[0]); end
        step; step;
        reset = 1'b0;
        step;
        do_req(0, 1'b1, 8'h01, 32'h0, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 4 || nrd !== 1) begin errors++; $display("FAIL rst_after_read: got rdy=%0d rd=%0d expected 4/1", rdy, nrd); end
        checks++; if (dout[0] !== 32'h0C0F_FEE1) begin errors++; $display("FAIL rst_after_data: got %h expected 0c0ffee1", dout[0]); end
        step;
    endtask

    task automatic test_latency_sweep;
        int rdy, nrd, nwr, nb;
        do_req(1, 1'b1, 8'h42, 32'h0, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 3 || nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL sweep_rd1: got rdy=%0d rd=%0d wr=%0d expected 3/1/0", rdy, nrd, nwr); end
        checks++; if (dout[1] !== 32'hA5A5_0042) begin errors++; $display("FAIL sweep_rd1_data: got %h expected a5a50042", dout[1]); end
        step;
        do_req(1, 1'b0, 8'h43, 32'h1111_2222, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 17 || nrd !== 0 || nwr !== 1) begin errors++; $display("FAIL sweep_wr15_u1: got rdy=%0d rd=%0d wr=%0d expected 17/0/1", rdy, nrd, nwr); end
        checks++; if (dout[1] !== 32'hA5A5_0042) begin errors++; $display("FAIL sweep_wr15_dout: got %h expected a5a50042", dout[1]); end
        step;
        do_req(2, 1'b1, 8'h7E, 32'h0, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 17 || nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL sweep_rd15: got rdy=%0d rd=%0d wr=%0d expected 17/1/0", rdy, nrd, nwr); end
        checks++; if (dout[2] !== 32'h5A5A_007E) begin errors++; $display("FAIL sweep_rd15_data: got %h expected 5a5a007e", dout[2]); end
        step;
        do_req(2, 1'b0, 8'h7F, 32'h3333_4444, rdy, nrd, nwr, nb);
        checks++; if (rdy !== 17 || nrd !== 0 || nwr !== 1) begin errors++; $display("FAIL sweep_wr15_u2: got rdy=%0d rd=%0d wr=%0d expected 17/0/1", rdy, nrd, nwr); end
        step;
    endtask

    task automatic test_back_to_back;
        int rdy, nrd, nwr, nb;
        logic [7:0]  a [2];
        logic [31:0] d [2];
        a[0] = 8'h20; d[0] = 32'hCAFE_0001;
        a[1] = 8'h21; d[1] = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            do_req(0, 1'b0, a[i], d[i], rdy, nrd, nwr, nb);
            checks++; if (rdy !== 3 || nwr !== 1) begin errors++; $display("FAIL b2b_write%0d: got rdy=%0d wr=%0d expected 3/1", i, rdy, nwr); end
            step;
            do_req(0, 1'b1, a[i], 32'h0, rdy, nrd, nwr, nb);
            checks++; if (rdy !== 4 || nrd !== 1) begin errors++; $display("FAIL b2b_read%0d: got rdy=%0d rd=%0d expected 4/1", i, rdy, nrd); end
            checks++; if (dout[0] !== d[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, dout[0], d[i]); end
            step;
        end
        checks++; if (ovr[0] !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b expected 0", ovr[0]); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_read;
        test_overrun;
        test_reset_mid_read;
        test_latency_sweep;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
